if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly downstream of the program counter. It drives the instruction-memory address from the current PC and absorbs the one-cycle synchronous IMEM read latency.
- Presents an aligned {instruction, PC, PC+4, valid} bundle to the decode stage.
- Handles stall (holds the bundle stable) and flush (inserts a NOP bubble), and keeps a retired-fetch counter.

Parameters:
- REG_DATA_WIDTH, 32: width of PC, instruction and counter datapaths.
- IMEM_ADDR_WIDTH, 10: word-address width of the instruction memory.
- NOP_INSTR, 32'h00000013: encoding driven on bubbles (addi x0,x0,0).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- IF_PC  in  32  current PC from the PC unit.
- IF_Stall  in  1  freeze the decode bundle (hazard unit).
- IF_Flush  in  1  squash the instruction entering decode (jump/branch taken).
- IMEM_Addr  out  IMEM_ADDR_WIDTH  word address = IF_PC[IMEM_ADDR_WIDTH+1:2], combinational.
- IMEM_Data  in  32  IMEM read data, valid one cycle after IMEM_Addr (memory reads every cycle).
- ID_Instruction  out  32  instruction for decode.
- ID_PC  out  32  PC of ID_Instruction.
- ID_PC_Plus4  out  32  ID_PC + 4, mod 2^32.
- ID_Valid  out  1  bundle is a real instruction (0 = bubble).
- ID_Misaligned  out  1  ID_PC[1:0] != 0; meaningful only when ID_Valid=1.
- ID_FetchCount  out  32  number of valid bundles accepted by decode.

Behaviour:
- Registers: pc_q (32), hold_q (32), state, cnt_q (32).
- State machine states: FILL, RUN, HOLD, BUBBLE.
- Reset (edge with Reset=1):
  - state=FILL, pc_q=0, hold_q=NOP_INSTR, cnt_q=0.
  - Outputs on the following cycle: ID_Instruction=NOP_INSTR, ID_PC=0, ID_PC_Plus4=4, ID_Valid=0, ID_Misaligned=0, ID_FetchCount=0.
  - Reset overrides Stall and Flush, including mid-stall.
- Output mux:
  - RUN: ID_Instruction=IMEM_Data.
  - HOLD: ID_Instruction=hold_q.
  - FILL/BUBBLE: ID_Instruction=NOP_INSTR, ID_Valid=0.
  - ID_Valid=1 only in RUN and HOLD.
  - ID_PC=pc_q in all states.
- Transition priority at each edge (not in reset): Flush > Stall > advance.
- Flush=1, from any state:
  - state<=BUBBLE, pc_q<=IF_PC.
  - Squashed instruction is not counted.
- Stall=1, Flush=0:
  - From RUN: hold_q<=IMEM_Data (captures the instruction currently shown), state<=HOLD, pc_q unchanged.
  - From HOLD: no change.
  - From FILL/BUBBLE: stay, pc_q unchanged.
- Advance (Stall=0, Flush=0): pc_q<=IF_PC, state<=RUN. If state was RUN or HOLD, cnt_q<=cnt_q+1 (wraps at 2^32).
- Latency: the instruction at address A (IF_PC=A in cycle n) appears on ID_* in cycle n+1, absent stall/flush.
- Stall-release coherence: the PC unit holds IF_PC during stall, so IMEM_Data on the release cycle already corresponds to the new pc_q. No refetch is needed.
- Simultaneous Stall and Flush: Flush wins; the bubble is shown next cycle.
- BUBBLE with Stall held: the bubble persists and the counter does not increment.
- IMEM_Addr is purely combinational from IF_PC; IF_PC[1:0] are ignored for addressing and only reported via ID_Misaligned.

Test Plan:
- Reset then free-run, IMEM[k]=0x1000_0000+k, IF_PC=0,4,8 -> cycle 1: ID_Valid=0, NOP; cycle 2: ID_PC=0, ID_Instruction=0x10000000; cycle 3: ID_PC=4, ID_Instruction=0x10000001, ID_PC_Plus4=8; ID_FetchCount increments once per valid cycle.
- Stall 3 cycles while ID_PC=8 (IF_PC held 12) -> ID_Instruction=IMEM[2], ID_PC=8 for all 3 cycles; after release ID_PC=12, ID_Instruction=IMEM[3]; count unchanged during stall.
- Flush with ID_PC=16 -> next cycle ID_Valid=0, ID_Instruction=0x00000013; following cycle ID_PC=IF_PC (jump target 0x40) with IMEM[16]; squashed instruction not counted.
- Stall and Flush asserted together in HOLD -> BUBBLE next cycle; Stall held 2 more cycles -> still bubble, count frozen.
- Reset asserted mid-stall -> next cycle ID_Valid=0, ID_PC=0, ID_FetchCount=0, ID_Instruction=NOP.
- IF_PC=0x0000_0006 and cnt_q preloaded to 0xFFFF_FFFF -> IMEM_Addr=1, ID_Misaligned=1; after one valid advance ID_FetchCount wraps to 0; IF_PC=0xFFFF_FFFC gives ID_PC_Plus4=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives IMEM from the PC, absorbs the one-cycle IMEM read
// latency and presents an aligned {instruction, PC, PC+4, valid} bundle to decode.
module if_fetch_stage #(
   parameter int                        REG_DATA_WIDTH  = 32,
   parameter int                        IMEM_ADDR_WIDTH = 10,
   parameter logic [REG_DATA_WIDTH-1:0] NOP_INSTR       = 32'h0000_0013
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [REG_DATA_WIDTH-1:0]  IF_PC,
   input  logic                       IF_Stall,
   input  logic                       IF_Flush,
   output logic [IMEM_ADDR_WIDTH-1:0] IMEM_Addr,
   input  logic [REG_DATA_WIDTH-1:0]  IMEM_Data,
   output logic [REG_DATA_WIDTH-1:0]  ID_Instruction,
   output logic [REG_DATA_WIDTH-1:0]  ID_PC,
   output logic [REG_DATA_WIDTH-1:0]  ID_PC_Plus4,
   output logic                       ID_Valid,
   output logic                       ID_Misaligned,
   output logic [REG_DATA_WIDTH-1:0]  ID_FetchCount
);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2,
      BUBBLE = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic [REG_DATA_WIDTH-1:0] pc_q, pc_d;
   logic [REG_DATA_WIDTH-1:0] hold_q, hold_d;
   logic [REG_DATA_WIDTH-1:0] cnt_q, cnt_d;

   function automatic logic [REG_DATA_WIDTH-1:0] pc_plus4(input logic [REG_DATA_WIDTH-1:0] pc);
      return pc + REG_DATA_WIDTH'(4);
   endfunction

   function automatic logic is_misaligned(input logic [REG_DATA_WIDTH-1:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

   // Word address straight from the PC; the byte-offset bits only feed ID_Misaligned.
   assign IMEM_Addr = IF_PC[IMEM_ADDR_WIDTH+1:2];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= FILL;
         pc_q    <= '0;
         hold_q  <= NOP_INSTR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      if (IF_Flush) begin
         state_d = BUBBLE;
         pc_d    = IF_PC;
      end else if (IF_Stall) begin
         // Only RUN has a live IMEM word that must be frozen; other states already hold.
         if (state_q == RUN) begin
            hold_d  = IMEM_Data;
            state_d = HOLD;
         end
      end else begin
         state_d = RUN;
         pc_d    = IF_PC;
         if ((state_q == RUN) || (state_q == HOLD)) begin
            cnt_d = cnt_q + REG_DATA_WIDTH'(1);
         end
      end
   end

   always_comb begin
      ID_Instruction = NOP_INSTR;
      ID_Valid       = 1'b0;
      case (state_q)
         RUN: begin
            ID_Instruction = IMEM_Data;
            ID_Valid       = 1'b1;
         end
         HOLD: begin
            ID_Instruction = hold_q;
            ID_Valid       = 1'b1;
         end
         default: begin
            ID_Instruction = NOP_INSTR;
            ID_Valid       = 1'b0;
         end
      endcase
   end

   assign ID_PC         = pc_q;
   assign ID_PC_Plus4   = pc_plus4(pc_q);
   assign ID_Misaligned = is_misaligned(pc_q);
   assign ID_FetchCount = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a synchronous IMEM model holding 0x1000_0000+k
// feeds the stage while a linear sequence of steps drives PC, stall, flush and reset.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        Clk;
   logic        Reset;
   logic [31:0] IF_PC;
   logic        IF_Stall;
   logic        IF_Flush;
   logic [9:0]  IMEM_Addr;
   logic [31:0] IMEM_Data;
   logic [31:0] ID_Instruction;
   logic [31:0] ID_PC;
   logic [31:0] ID_PC_Plus4;
   logic        ID_Valid;
   logic        ID_Misaligned;
   logic [31:0] ID_FetchCount;

   logic [31:0] mem [0:1023];
   int          checks = 0;
   int          passes = 0;

   if_fetch_stage dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .IF_PC          (IF_PC),
      .IF_Stall       (IF_Stall),
      .IF_Flush       (IF_Flush),
      .IMEM_Addr      (IMEM_Addr),
      .IMEM_Data      (IMEM_Data),
      .ID_Instruction (ID_Instruction),
      .ID_PC          (ID_PC),
      .ID_PC_Plus4    (ID_PC_Plus4),
      .ID_Valid       (ID_Valid),
      .ID_Misaligned  (ID_Misaligned),
      .ID_FetchCount  (ID_FetchCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) IMEM_Data <= mem[IMEM_Addr];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic check_bundle(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                               input logic vld, input logic [31:0] cnt);
      check({tag, ".instr"}, ID_Instruction, instr);
      check({tag, ".pc"}, ID_PC, pc);
      check({tag, ".pc4"}, ID_PC_Plus4, pc + 32'd4);
      check({tag, ".valid"}, {31'd0, ID_Valid}, {31'd0, vld});
      check({tag, ".count"}, ID_FetchCount, cnt);
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
      IMEM_Data = 32'h0;
      Reset = 1'b1; IF_PC = 32'h0; IF_Stall = 1'b0; IF_Flush = 1'b0;
      tick();
      check_bundle("reset", NOP, 32'h0, 1'b0, 32'd0);
      check("reset.misal", {31'd0, ID_Misaligned}, 32'd0);

      // Free run from PC 0.
      Reset = 1'b0; IF_PC = 32'h0;
      tick();
      check_bundle("run0", 32'h1000_0000, 32'h0, 1'b1, 32'd0);
      IF_PC = 32'h4;
      tick();
      check_bundle("run4", 32'h1000_0001, 32'h4, 1'b1, 32'd1);
      IF_PC = 32'h8;
      tick();
      check_bundle("run8", 32'h1000_0002, 32'h8, 1'b1, 32'd2);

      // Three-cycle stall with the PC unit holding 12.
      IF_PC = 32'hC; IF_Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_bundle("stall", 32'h1000_0002, 32'h8, 1'b1, 32'd2);
      end
      IF_Stall = 1'b0;
      tick();
      check_bundle("release", 32'h1000_0003, 32'hC, 1'b1, 32'd3);
      IF_PC = 32'h10;
      tick();
      check_bundle("run16", 32'h1000_0004, 32'h10, 1'b1, 32'd4);

      // Flush to jump target 0x40.
      IF_PC = 32'h40; IF_Flush = 1'b1;
      tick();
      check_bundle("flush", NOP, 32'h40, 1'b0, 32'd4);
      IF_Flush = 1'b0;
      tick();
      check_bundle("target", 32'h1000_0010, 32'h40, 1'b1, 32'd4);

      // Stall and flush together while in HOLD, then stall held over the bubble.
      IF_PC = 32'h44;
      tick();
      check_bundle("run44", 32'h1000_0011, 32'h44, 1'b1, 32'd5);
      IF_Stall = 1'b1;
      tick();
      check_bundle("hold44", 32'h1000_0011, 32'h44, 1'b1, 32'd5);
      IF_PC = 32'h80; IF_Flush = 1'b1;
      tick();
      check_bundle("stflush", NOP, 32'h80, 1'b0, 32'd5);
      IF_Flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_bundle("bubstall", NOP, 32'h80, 1'b0, 32'd5);
      end

      // Reset arriving while stalled in HOLD.
      IF_Stall = 1'b0;
      tick();
      check_bundle("run80", 32'h1000_0020, 32'h80, 1'b1, 32'd5);
      IF_Stall = 1'b1;
      tick();
      check_bundle("hold80", 32'h1000_0020, 32'h80, 1'b1, 32'd6 - 32'd1);
      Reset = 1'b1;
      tick();
      check_bundle("rststall", NOP, 32'h0, 1'b0, 32'd0);

      // Misaligned PC, counter wrap and PC+4 wrap.
      Reset = 1'b0; IF_Stall = 1'b0; IF_PC = 32'h0;
      tick();
      check_bundle("rerun", 32'h1000_0000, 32'h0, 1'b1, 32'd0);
      IF_PC = 32'h6;
      #1;
      check("addr6", {22'd0, IMEM_Addr}, 32'd1);
      tick();
      check_bundle("misal", 32'h1000_0001, 32'h6, 1'b1, 32'd1);
      check("misal.flag", {31'd0, ID_Misaligned}, 32'd1);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      #1;
      check("preload", ID_FetchCount, 32'hFFFF_FFFF);
      IF_PC = 32'hFFFF_FFFC;
      #1;
      check("addrtop", {22'd0, IMEM_Addr}, 32'd1023);
      tick();
      check_bundle("wrap", 32'h1000_03FF, 32'hFFFF_FFFC, 1'b1, 32'd0);
      check("wrap.misal", {31'd0, ID_Misaligned}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
